// File: rtl/kf_frame_seq_pkg.sv
// Shared constants for the Kalman-filter frame sequencer: fixed-point width
// defaults, watchdog default and the sequencer FSM state encodings.
package kf_frame_seq_pkg;

  localparam int FXP_N      = 16;
  localparam int FXP_FRAC   = 8;
  localparam int KF_TMO_DEF = 64;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_BUSY   = 2'd2;

endpackage

// File: rtl/kf_meas_fifo.sv
// Measurement FIFO: DEPTH entries of two N-bit words, combinational head,
// no full-bypass. Push is ignored when full, pop is ignored when empty.
module kf_meas_fifo
  import kf_frame_seq_pkg::*;
#(
  parameter  int N     = FXP_N,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [N-1:0]  push_z00,
  input  logic [N-1:0]  push_z10,
  input  logic          pop,
  output logic [N-1:0]  head_z00,
  output logic [N-1:0]  head_z10,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("kf_meas_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [2*N-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign {head_z00, head_z10} = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_z00, push_z10};
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kf_frame_seq.sv
// Frame sequencer: queues measurements, launches one filter-core run per
// measurement, guards each run with a watchdog and streams indexed results.
module kf_frame_seq
  import kf_frame_seq_pkg::*;
#(
  parameter int N     = FXP_N,
  parameter int FRAC  = FXP_FRAC,
  parameter int DEPTH = 4,
  parameter int TMO   = KF_TMO_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                meas_valid,
  output logic                meas_ready,
  input  logic signed [N-1:0] meas_z00,
  input  logic signed [N-1:0] meas_z10,
  input  logic                init_load,
  input  logic signed [N-1:0] init_x00,
  input  logic signed [N-1:0] init_x10,
  output logic                kf_start,
  input  logic                kf_done,
  input  logic signed [N-1:0] kf_x00_post,
  input  logic signed [N-1:0] kf_x10_post,
  output logic signed [N-1:0] kf_x00_prev,
  output logic signed [N-1:0] kf_x10_prev,
  output logic signed [N-1:0] kf_z00_meas,
  output logic signed [N-1:0] kf_z10_meas,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_x00,
  output logic signed [N-1:0] out_x10,
  output logic [15:0]         out_idx,
  output logic                err_tmo
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(TMO + 1);
  localparam logic [WW-1:0] TMO_LAST = WW'(TMO - 1);

  if ((FRAC < 0) || (FRAC >= N)) begin : g_bad_frac
    $error("kf_frame_seq: FRAC must lie in [0, N)");
  end
  if (TMO < 2) begin : g_bad_tmo
    $error("kf_frame_seq: TMO must be at least 2");
  end

  logic [1:0]    state;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic [N-1:0]  head_z00;
  logic [N-1:0]  head_z10;
  logic          launch_go;
  logic          done_take;
  logic          tmo_hit;
  logic [WW-1:0] wdog;
  logic [15:0]   frame_cnt;

  // A new frame may start while the previous result is being handed off.
  assign launch_go  = (state == ST_IDLE) && (fifo_count != '0) && (!out_valid || out_ready);
  assign done_take  = (state == ST_BUSY) && kf_done;
  assign tmo_hit    = (state == ST_BUSY) && !kf_done && (wdog == TMO_LAST);
  assign meas_ready = !fifo_full;
  assign kf_start   = (state == ST_LAUNCH);

  kf_meas_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (meas_valid),
    .push_z00 (meas_z00),
    .push_z10 (meas_z10),
    .pop      (launch_go),
    .head_z00 (head_z00),
    .head_z10 (head_z10),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      wdog  <= '0;
    end else begin
      case (state)
        ST_IDLE:   if (launch_go) state <= ST_LAUNCH;
        ST_LAUNCH: state <= ST_BUSY;
        ST_BUSY:   if (done_take || tmo_hit) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
      // Cycle count since LAUNCH; it is 0 during the LAUNCH cycle itself.
      if (launch_go)             wdog <= '0;
      else if (state != ST_IDLE) wdog <= wdog + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kf_z00_meas <= '0;
      kf_z10_meas <= '0;
      kf_x00_prev <= '0;
      kf_x10_prev <= '0;
    end else begin
      if (launch_go) begin
        kf_z00_meas <= head_z00;
        kf_z10_meas <= head_z10;
      end
      if (done_take) begin
        kf_x00_prev <= kf_x00_post;
        kf_x10_prev <= kf_x10_post;
      end else if (init_load && (state == ST_IDLE) && !launch_go) begin
        kf_x00_prev <= init_x00;
        kf_x10_prev <= init_x10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_x00   <= '0;
      out_x10   <= '0;
      out_idx   <= '0;
      frame_cnt <= '0;
      err_tmo   <= 1'b0;
    end else begin
      if (done_take) begin
        out_valid <= 1'b1;
        out_x00   <= kf_x00_post;
        out_x10   <= kf_x10_post;
        out_idx   <= frame_cnt;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (tmo_hit) err_tmo <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kf_frame_seq.sv
// Scoreboard bench for kf_frame_seq with a behavioural filter-core model that
// answers each kf_start with kf_done a fixed latency later.
module tb_kf_frame_seq;
  import kf_frame_seq_pkg::*;

  localparam int N     = 16;
  localparam int FRAC  = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;
  localparam int LAT   = 37;

  typedef struct {
    logic signed [N-1:0] x00;
    logic signed [N-1:0] x10;
    logic [15:0]         idx;
  } out_t;

  typedef struct {
    logic signed [N-1:0] z00;
    logic signed [N-1:0] z10;
    logic signed [N-1:0] p00;
    logic signed [N-1:0] p10;
  } op_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                meas_valid = 1'b0;
  logic                meas_ready;
  logic signed [N-1:0] meas_z00 = '0;
  logic signed [N-1:0] meas_z10 = '0;
  logic                init_load = 1'b0;
  logic signed [N-1:0] init_x00 = '0;
  logic signed [N-1:0] init_x10 = '0;
  logic                kf_start;
  logic                kf_done = 1'b0;
  logic signed [N-1:0] kf_x00_post = '0;
  logic signed [N-1:0] kf_x10_post = '0;
  logic signed [N-1:0] kf_x00_prev;
  logic signed [N-1:0] kf_x10_prev;
  logic signed [N-1:0] kf_z00_meas;
  logic signed [N-1:0] kf_z10_meas;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic signed [N-1:0] out_x00;
  logic signed [N-1:0] out_x10;
  logic [15:0]         out_idx;
  logic                err_tmo;

  kf_frame_seq #(
    .N     (N),
    .FRAC  (FRAC),
    .DEPTH (DEPTH),
    .TMO   (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .meas_valid  (meas_valid),
    .meas_ready  (meas_ready),
    .meas_z00    (meas_z00),
    .meas_z10    (meas_z10),
    .init_load   (init_load),
    .init_x00    (init_x00),
    .init_x10    (init_x10),
    .kf_start    (kf_start),
    .kf_done     (kf_done),
    .kf_x00_post (kf_x00_post),
    .kf_x10_post (kf_x10_post),
    .kf_x00_prev (kf_x00_prev),
    .kf_x10_prev (kf_x10_prev),
    .kf_z00_meas (kf_z00_meas),
    .kf_z10_meas (kf_z10_meas),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x00     (out_x00),
    .out_x10     (out_x10),
    .out_idx     (out_idx),
    .err_tmo     (err_tmo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard state: expected launches, expected results, and the bench's own copy of x_prev.
  out_t                exp_q[$];
  op_t                 op_q[$];
  int                  hs_log[$];
  logic signed [N-1:0] m_p00 = '0;
  logic signed [N-1:0] m_p10 = '0;
  logic [15:0]         m_idx = '0;

  int core_mode = 0;
  int rst_gen = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int done_cyc = -100;
  int last_gap = 0;

  // Filter-core model: post00 = prev00 + z00, post10 = prev10 - z10.
  initial begin : core_model
    op_t op;
    int  gen;
    forever begin
      @(negedge clk);
      if (kf_start === 1'b1) begin
        start_cnt++;
        last_gap  = cyc - done_cyc;
        start_cyc = cyc;
        gen       = rst_gen;
        if (op_q.size() == 0) begin
          check("start_unexpected", 32'd1, 32'd0);
        end else begin
          op = op_q.pop_front();
          check("launch_z00", kf_z00_meas, op.z00);
          check("launch_z10", kf_z10_meas, op.z10);
          check("launch_p00", kf_x00_prev, op.p00);
          check("launch_p10", kf_x10_prev, op.p10);
          if (core_mode == 0) begin
            repeat (LAT) @(posedge clk);
            #1;
            if (gen == rst_gen) begin
              check("busy_z00", kf_z00_meas, op.z00);
              check("busy_z10", kf_z10_meas, op.z10);
              check("busy_p00", kf_x00_prev, op.p00);
              check("busy_p10", kf_x10_prev, op.p10);
            end
            kf_x00_post = op.p00 + op.z00;
            kf_x10_post = op.p10 - op.z10;
            kf_done     = 1'b1;
            done_cyc    = cyc;
            @(posedge clk);
            #1 kf_done = 1'b0;
          end
        end
      end
    end
  end

  initial begin : out_monitor
    out_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        hs_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("out_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_x00", out_x00, e.x00);
          check("out_x10", out_x10, e.x10);
          check("out_idx", out_idx, e.idx);
        end
      end else if (out_valid === 1'b1 && exp_q.size() == 0) begin
        check("out_unexpected_held", 32'd1, 32'd0);
      end
    end
  end

  task automatic push_meas(input logic signed [N-1:0] z00, input logic signed [N-1:0] z10,
                           input bit expect_out);
    out_t e;
    op_t  o;
    int   n = 0;
    meas_valid = 1'b1;
    meas_z00   = z00;
    meas_z10   = z10;
    forever begin
      @(negedge clk);
      if (meas_ready === 1'b1) break;
      n++;
      if (n > 2000) begin
        check("push_timeout", 32'd0, 32'd1);
        meas_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1 meas_valid = 1'b0;
    o = '{z00, z10, m_p00, m_p10};
    op_q.push_back(o);
    if (expect_out) begin
      m_p00 = m_p00 + z00;
      m_p10 = m_p10 - z10;
      e = '{m_p00, m_p10, m_idx};
      m_idx++;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || op_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(exp_q.size() == 0 && op_q.size() == 0), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_out_valid(input int budget);
    int n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic apply_reset();
    rst_gen++;
    rst_n      = 1'b0;
    meas_valid = 1'b0;
    init_load  = 1'b0;
    out_ready  = 1'b1;
    core_mode  = 0;
    exp_q.delete();
    op_q.delete();
    m_p00 = '0;
    m_p10 = '0;
    m_idx = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin : global_bound
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int s0;
    int n;

    // Reset values, then a single frame.
    apply_reset();
    check("rst_meas_ready", 32'(meas_ready), 32'd1);
    check("rst_kf_start", 32'(kf_start), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_x00", out_x00, 32'd0);
    check("rst_out_x10", out_x10, 32'd0);
    check("rst_out_idx", out_idx, 32'd0);
    check("rst_err_tmo", 32'(err_tmo), 32'd0);
    check("rst_prev00", kf_x00_prev, 32'd0);
    check("rst_prev10", kf_x10_prev, 32'd0);
    check("rst_z00", kf_z00_meas, 32'd0);
    s0 = start_cnt;
    @(posedge clk); #1;
    push_meas(16'sh0100, 16'sh0200, 1'b1);
    wait_drain(300);
    check("t1_start_pulses", start_cnt - s0, 32'd1);

    // FIFO fill with the result slot blocked, then ordered drain.
    apply_reset();
    out_ready = 1'b0;
    s0 = start_cnt;
    @(posedge clk); #1;
    push_meas(16'sh0011, 16'sh0022, 1'b1);
    wait_out_valid(300);
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++)
      push_meas(16'(16'sh0030 + i), 16'(16'sh0041 * (i + 1)), 1'b1);
    @(negedge clk);
    check("t2_ready_low_full", 32'(meas_ready), 32'd0);
    check("t2_one_start", start_cnt - s0, 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    push_meas(16'sh7FF0, -16'sh0005, 1'b1);
    wait_drain(1500);
    check("t2_done_to_start", last_gap, 32'd2);
    check("t2_next_idx", 32'(m_idx), 32'd6);

    // Output back-pressure holds the result and blocks the next launch.
    apply_reset();
    out_ready = 1'b0;
    s0 = start_cnt;
    @(posedge clk); #1;
    push_meas(16'sh0123, 16'sh0456, 1'b1);
    push_meas(-16'sh0100, 16'sh0010, 1'b1);
    wait_out_valid(300);
    for (int k = 0; k < 4; k++) begin
      repeat (25) @(negedge clk);
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_x00", out_x00, exp_q[0].x00);
      check("t3_hold_x10", out_x10, exp_q[0].x10);
    end
    check("t3_one_start", start_cnt - s0, 32'd1);
    hs_log.delete();
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain(300);
    check("t3_start_after_hs", start_cyc - hs_log[0], 32'd1);

    // Watchdog: silent core, then a normal frame on the unchanged state.
    apply_reset();
    core_mode = 1;
    s0 = start_cnt;
    @(posedge clk); #1;
    push_meas(16'sh0200, 16'sh0300, 1'b0);
    n = 0;
    while (start_cnt == s0 && n < 20) begin @(negedge clk); n++; end
    check("t4_started", start_cnt - s0, 32'd1);
    n = 0;
    while (err_tmo !== 1'b1 && n < 4 * TMO) begin @(negedge clk); n++; end
    check("t4_tmo_cycle", cyc - start_cyc, 32'(TMO));
    check("t4_no_out", 32'(out_valid), 32'd0);
    core_mode = 0;
    @(posedge clk); #1;
    push_meas(16'sh0005, 16'sh0006, 1'b1);
    wait_drain(300);
    check("t4_err_sticky", 32'(err_tmo), 32'd1);

    // Initial-state load, then chained frames.
    apply_reset();
    check("t5_err_cleared", 32'(err_tmo), 32'd0);
    @(posedge clk); #1;
    init_x00  = 16'sh0800;
    init_x10  = 16'shF800;
    init_load = 1'b1;
    @(posedge clk); #1 init_load = 1'b0;
    m_p00 = 16'sh0800;
    m_p10 = 16'shF800;
    @(negedge clk);
    check("t5_prev00_loaded", kf_x00_prev, 16'sh0800);
    check("t5_prev10_loaded", kf_x10_prev, 16'shF800);
    @(posedge clk); #1;
    push_meas(16'sh0101, 16'sh0202, 1'b1);
    push_meas(16'sh0303, -16'sh0404, 1'b1);
    wait_drain(500);

    // Reset in the middle of BUSY aborts the frame without output.
    apply_reset();
    s0 = start_cnt;
    @(posedge clk); #1;
    push_meas(16'sh0777, 16'sh0888, 1'b0);
    n = 0;
    while (start_cnt == s0 && n < 20) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    #2;
    rst_gen++;
    exp_q.delete();
    op_q.delete();
    rst_n = 1'b0;
    #1;
    check("t6_kf_start", 32'(kf_start), 32'd0);
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_out_idx", out_idx, 32'd0);
    check("t6_z00", kf_z00_meas, 32'd0);
    check("t6_meas_ready", 32'(meas_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("t6_no_out_after", 32'(out_valid), 32'd0);
    check("t6_no_restart", start_cnt - s0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
